// File: rtl/fft_pkg.sv
// Shared types and helpers for the fft block, its output serializer and their benches.
package fft_pkg;

    localparam int unsigned SAMPLE_W = 32;
    localparam int unsigned COMP_W   = 16;
    localparam int unsigned FFT_LEN  = 8;

    typedef struct packed {
        logic [COMP_W-1:0] re;
        logic [COMP_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'd0,
        SLOT_FULL     = 2'd1,
        SLOT_DRAINING = 2'd2
    } slot_state_t;

    // Reverse the low 'width' bits of idx.
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < width; b++) begin
            r = (r << 1) | ((idx >> b) & 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_slot.sv
// One frame of sample storage with its EMPTY/FULL/DRAINING state and an indexed read port.
module fft_frame_slot
    import fft_pkg::*;
#(
    parameter int unsigned LEN = FFT_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  cplx_t [LEN-1:0]          i_wr_data,
    input  logic                     i_start,
    input  logic                     i_done,
    input  logic [$clog2(LEN)-1:0]   i_rd_idx,
    output slot_state_t              o_state,
    output cplx_t                    o_rd_data_c
);

    slot_state_t     r_state;
    cplx_t [LEN-1:0] r_data;

    // A slot may be written and start draining on the same edge (bypass to the output).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else if (i_done) begin
            r_state <= SLOT_EMPTY;
        end else if (i_start) begin
            r_state <= SLOT_DRAINING;
        end else if (i_wr_en) begin
            r_state <= SLOT_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data <= i_wr_data;
        end
    end

    assign o_state     = r_state;
    assign o_rd_data_c = r_data[i_rd_idx];

endmodule

// File: rtl/fft_out_serializer.sv
// Captures full fft frames into a ping-pong pair of slots and streams them out one
// sample per cycle, optionally in bit-reversed order and arithmetically scaled.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int unsigned LEN    = FFT_LEN,
    parameter int unsigned BITREV = 0,
    parameter int unsigned SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_valid,
    input  logic [LEN*SAMPLE_W-1:0]   frame_data,
    output logic                      frame_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SAMPLE_W-1:0]       out_data,
    output logic [$clog2(LEN)-1:0]    out_index,
    output logic                      out_last,
    output logic                      overflow
);

    localparam int unsigned IDX_W = $clog2(LEN);

    logic                 r_wr;
    logic                 r_rd;
    logic [IDX_W-1:0]     r_k;
    logic                 r_out_valid;
    logic [SAMPLE_W-1:0]  r_out_data;
    logic [IDX_W-1:0]     r_out_index;
    logic                 r_out_last;
    logic                 r_overflow;

    cplx_t [LEN-1:0]      w_frame;
    slot_state_t          w_state   [2];
    cplx_t                w_rd_data [2];
    logic                 w_frame_ready;
    logic                 w_capture;
    logic                 w_xfer;
    logic                 w_last_xfer;
    logic                 w_load;
    logic                 w_start;
    logic                 w_src;
    logic [IDX_W-1:0]     w_next_k;
    logic [IDX_W-1:0]     w_src_idx;
    cplx_t                w_sample;
    logic [SAMPLE_W-1:0]  w_scaled;

    assign w_frame       = frame_data;
    assign w_frame_ready = (w_state[r_wr] == SLOT_EMPTY);
    assign w_capture     = frame_valid && w_frame_ready;
    assign w_xfer        = r_out_valid && out_ready;
    assign w_last_xfer   = w_xfer && r_out_last;

    for (genvar g = 0; g < 2; g++) begin : g_slot
        fft_frame_slot #(.LEN(LEN)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_wr_en     (w_capture && (r_wr == 1'(g))),
            .i_wr_data   (w_frame),
            .i_start     (w_start && (w_src == 1'(g))),
            .i_done      (w_last_xfer && (r_rd == 1'(g))),
            .i_rd_idx    (w_src_idx),
            .o_state     (w_state[g]),
            .o_rd_data_c (w_rd_data[g])
        );
    end

    // Choose which sample the output register loads at this edge, if any.
    always_comb begin
        w_load   = 1'b0;
        w_start  = 1'b0;
        w_src    = r_rd;
        w_next_k = '0;
        if (w_xfer && !r_out_last) begin
            w_load   = 1'b1;
            w_next_k = r_k + IDX_W'(1);
        end else if (!r_out_valid || w_xfer) begin
            w_src   = r_out_valid ? ~r_rd : r_rd;
            w_start = (w_state[w_src] == SLOT_FULL) || (w_capture && (r_wr == w_src));
            w_load  = w_start;
        end
    end

    assign w_src_idx = (BITREV != 0) ? IDX_W'(bitrev(32'(w_next_k), IDX_W)) : w_next_k;
    // A slot being captured on this very edge is read straight from the input frame.
    assign w_sample  = (w_capture && (r_wr == w_src)) ? w_frame[w_src_idx] : w_rd_data[w_src];
    assign w_scaled  = {COMP_W'($signed(w_sample.re) >>> SHIFT),
                        COMP_W'($signed(w_sample.im) >>> SHIFT)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr        <= 1'b0;
            r_rd        <= 1'b0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= frame_valid && !w_frame_ready;
            if (w_capture) begin
                r_wr <= ~r_wr;
            end
            if (w_last_xfer) begin
                r_rd <= ~r_rd;
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_k         <= w_next_k;
                r_out_data  <= w_scaled;
                r_out_index <= w_src_idx;
                r_out_last  <= (w_next_k == IDX_W'(LEN - 1));
            end else if (w_last_xfer) begin
                r_out_valid <= 1'b0;
                r_k         <= '0;
            end
        end
    end

    assign frame_ready = w_frame_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_index   = r_out_index;
    assign out_last    = r_out_last;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Bench for fft_out_serializer: three variants (natural, bit-reversed, SHIFT=2) share one
// stimulus; each has a frame-queue model checked every cycle plus literal spot checks.
module tb_fft_out_serializer;

    localparam int unsigned LEN = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               frame_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [LEN*32-1:0]  frame_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned BR = (g == 1) ? 1 : 0;
        localparam int unsigned SH = (g == 2) ? 2 : 0;

        logic        w_fr, w_ov, w_ol, w_ofl;
        logic [31:0] w_od;
        logic [2:0]  w_oi;

        fft_out_serializer #(.LEN(LEN), .BITREV(BR), .SHIFT(SH)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .frame_valid (frame_valid),
            .frame_data  (frame_data),
            .frame_ready (w_fr),
            .out_valid   (w_ov),
            .out_ready   (out_ready),
            .out_data    (w_od),
            .out_index   (w_oi),
            .out_last    (w_ol),
            .overflow    (w_ofl)
        );

        // Expected {data, index, last} for the k-th emitted sample of frame f.
        function automatic logic [35:0] exp_sample(input logic [LEN*32-1:0] f, input int k);
            logic [2:0]  kk;
            logic [2:0]  idx;
            logic [15:0] re16, im16;
            int          re, im;
            kk   = 3'(k);
            idx  = (BR != 0) ? {kk[0], kk[1], kk[2]} : kk;
            re16 = f[32*idx+16 +: 16];
            im16 = f[32*idx +: 16];
            re   = $signed(re16);
            im   = $signed(im16);
            re   = re >>> SH;
            im   = im >>> SH;
            return {re[15:0], im[15:0], idx, (k == LEN - 1)};
        endfunction

        logic [35:0] q[$];
        int          nfr = 0;
        bit          ovf_exp = 1'b0;

        always @(posedge clk or posedge rst) begin : model
            bit rdy;
            if (rst) begin
                q.delete();
                nfr     = 0;
                ovf_exp = 1'b0;
            end else begin
                rdy = (nfr < 2);
                if (q.size() > 0 && out_ready) begin
                    if (q[0][0]) nfr--;
                    void'(q.pop_front());
                end
                ovf_exp = frame_valid && !rdy;
                if (frame_valid && rdy) begin
                    for (int k = 0; k < LEN; k++) q.push_back(exp_sample(frame_data, k));
                    nfr++;
                end
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                chk($sformatf("dut%0d out_valid", g), 64'(w_ov), 64'(q.size() > 0));
                chk($sformatf("dut%0d frame_ready", g), 64'(w_fr), 64'(nfr < 2));
                chk($sformatf("dut%0d overflow", g), 64'(w_ofl), 64'(ovf_exp));
                if (q.size() > 0)
                    chk($sformatf("dut%0d sample", g), 64'({w_od, w_oi, w_ol}), 64'(q[0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [LEN*32-1:0] d);
        frame_valid = 1'b1;
        frame_data  = d;
        step();
        frame_valid = 1'b0;
        frame_data  = ~d;
    endtask

    logic [LEN*32-1:0] f1, fa, fb, fc, fs;
    logic [31:0] nat_tab [8];
    logic [31:0] rev_tab [8];
    logic [2:0]  rev_idx [8];
    logic [3:0]  pat;
    int          ntx;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nat_tab = '{32'h0001FFFF, 32'h0002FFFE, 32'h0003FFFD, 32'h0004FFFC,
                    32'h0005FFFB, 32'h0006FFFA, 32'h0007FFF9, 32'h0008FFF8};
        rev_tab = '{32'h0001FFFF, 32'h0005FFFB, 32'h0003FFFD, 32'h0007FFF9,
                    32'h0002FFFE, 32'h0006FFFA, 32'h0004FFFC, 32'h0008FFF8};
        rev_idx = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
        for (int j = 0; j < LEN; j++) begin
            f1[32*j +: 32] = {16'(j + 1), 16'(-(j + 1))};
            fa[32*j +: 32] = {16'hA000 + 16'(j), 16'h0A00 + 16'(j)};
            fb[32*j +: 32] = {16'hB000 + 16'(j), 16'h0B00 + 16'(j)};
            fc[32*j +: 32] = {16'hC000 + 16'(j), 16'h0C00 + 16'(j)};
            fs[32*j +: 32] = {16'(j * 1000 - 3000), 16'(7 - j * 4321)};
        end
        fs[31:0] = 32'h80000007;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst out_valid", 64'(g_dut[0].w_ov), 64'd0);
        chk("rst out_data", 64'(g_dut[0].w_od), 64'd0);
        chk("rst out_index", 64'(g_dut[0].w_oi), 64'd0);
        chk("rst out_last", 64'(g_dut[0].w_ol), 64'd0);
        chk("rst overflow", 64'(g_dut[0].w_ofl), 64'd0);
        chk("rst frame_ready", 64'(g_dut[0].w_fr), 64'd1);
        step();
        step();
        rst = 1'b0;
        step();

        // Single frame, natural and bit-reversed order
        out_ready = 1'b1;
        send(f1);
        for (int k = 0; k < LEN; k++) begin
            chk("nat valid", 64'(g_dut[0].w_ov), 64'd1);
            chk("nat data", 64'(g_dut[0].w_od), 64'(nat_tab[k]));
            chk("nat last", 64'(g_dut[0].w_ol), 64'(k == LEN - 1));
            chk("rev index", 64'(g_dut[1].w_oi), 64'(rev_idx[k]));
            chk("rev data", 64'(g_dut[1].w_od), 64'(rev_tab[k]));
            step();
        end
        chk("nat idle", 64'(g_dut[0].w_ov), 64'd0);
        step();

        // Backpressure: out_ready pattern 1,0,0,1
        pat = 4'b1001;
        ntx = 0;
        send(f1);
        for (int c = 0; c < 64 && ntx < LEN; c++) begin
            out_ready = pat[c % 4];
            if (g_dut[0].w_ov && out_ready) begin
                chk("bp index", 64'(g_dut[0].w_oi), 64'(ntx));
                ntx++;
            end
            step();
        end
        chk("bp transfers", 64'(ntx), 64'(LEN));
        chk("bp idle", 64'(g_dut[0].w_ov), 64'd0);
        step();

        // Ping-pong fill and overflow
        out_ready   = 1'b0;
        frame_valid = 1'b1;
        frame_data  = fa;
        step();
        chk("pp ready after A", 64'(g_dut[0].w_fr), 64'd1);
        frame_data = fb;
        step();
        chk("pp ready after B", 64'(g_dut[0].w_fr), 64'd0);
        frame_data = fc;
        step();
        frame_valid = 1'b0;
        chk("pp overflow pulse", 64'(g_dut[0].w_ofl), 64'd1);
        step();
        chk("pp overflow end", 64'(g_dut[0].w_ofl), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 2 * LEN; i++) begin
            chk("pp no bubble", 64'(g_dut[0].w_ov), 64'd1);
            if (i == 0) chk("pp A first", 64'(g_dut[0].w_od), 64'h00000000A0000A00);
            if (i == LEN) chk("pp B first", 64'(g_dut[0].w_od), 64'h00000000B0000B00);
            step();
        end
        chk("pp drained", 64'(g_dut[0].w_ov), 64'd0);
        step();

        // Scaling, then a capture on the edge of the last transfer
        send(fs);
        chk("shift data", 64'(g_dut[2].w_od), 64'h00000000E0000001);
        chk("noshift data", 64'(g_dut[0].w_od), 64'h0000000080000007);
        repeat (LEN - 1) step();
        send(f1);
        chk("b2b first", 64'(g_dut[0].w_od), 64'h000000000001FFFF);
        repeat (LEN + 2) step();

        // Asynchronous reset mid-stream
        send(fa);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("midrst out_valid", 64'(g_dut[0].w_ov), 64'd0);
        chk("midrst frame_ready", 64'(g_dut[0].w_fr), 64'd1);
        chk("midrst rev out_valid", 64'(g_dut[1].w_ov), 64'd0);
        step();
        rst = 1'b0;
        step();
        send(fb);
        chk("post-rst index", 64'(g_dut[0].w_oi), 64'd0);
        chk("post-rst data", 64'(g_dut[0].w_od), 64'h00000000B0000B00);
        repeat (LEN + 2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
- Downstream neighbour of the fft block: captures one full parallel output frame (LEN packed complex samples) and streams it out one sample per cycle on a valid/ready interface.
- Ping-pong two-frame buffer lets the fft produce a new frame while the previous one drains.
- Optional bit-reversed read order and per-component arithmetic scaling before output.

Parameters:
- LEN, 8, samples per frame; power of 2, minimum 2.
- BITREV, 0, 1 = emit samples in bit-reversed index order; 0 = natural order.
- SHIFT, 0, arithmetic right shift (0..15) applied to the real and imag 16-bit fields on output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- frame_valid  input  1  one-cycle pulse: frame_data holds a complete fft frame
- frame_data  input  LEN*32  sample j at [32*j+:32]; real in bits [32*j+16+:16], imag in bits [32*j+:16], both signed
- frame_ready  output  1  at least one buffer slot is free
- out_valid  output  1  out_data holds a valid sample
- out_ready  input  1  consumer accepts the sample this cycle
- out_data  output  32  {real[15:0], imag[15:0]} after scaling
- out_index  output  clog2(LEN)  bin index of out_data, i.e. the source j
- out_last  output  1  high with the final sample of a frame
- overflow  output  1  one-cycle pulse when a frame is dropped

Behaviour:
- Reset, asynchronous: both slots empty, write pointer and read pointer = slot 0, sample counter = 0. Outputs after reset: out_valid=0, out_data=0, out_index=0, out_last=0, overflow=0, frame_ready=1.
- Slot state machine, per slot: EMPTY -> FULL on capture; FULL -> DRAINING when selected by the read pointer; DRAINING -> EMPTY on the handshake of the last sample.
- frame_ready = (slot[wr] is EMPTY). It is combinational from registered state only.
- Capture: frame_valid && frame_ready
  - Stores frame_data into slot[wr] at the clock edge.
  - Marks the slot FULL and toggles wr.
- Drop: frame_valid && !frame_ready
  - Frame is discarded; nothing is written.
  - overflow = 1 for exactly the next cycle.
- Output latency: the first sample of a captured frame appears with out_valid=1 on the cycle after the capture edge when the output path is idle. Capture to first out_valid is 1 cycle.
- Handshake: a transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_index and out_last are held stable.
  - out_valid never drops without a transfer.
- Sample counter k runs 0..LEN-1.
  - out_index = k when BITREV=0; out_index = bitreverse(k) when BITREV=1.
  - out_data is taken from slot[rd] at out_index.
  - out_last = (k == LEN-1).
- After the transfer of the last sample: the slot becomes EMPTY, rd toggles and k is reset to 0.
  - If the other slot is FULL, its sample 0 is presented on the next cycle, back-to-back with no bubble.
  - Otherwise out_valid goes to 0.
- Simultaneous capture and last-sample transfer into the same slot is legal. frame_ready reflects the pre-edge state, so the freed slot is accepted from the following cycle.
- Scaling: each 16-bit field is shifted right arithmetically by SHIFT (sign-extended, truncated toward -inf). There is no rounding and no saturation. The fields are scaled independently.
- frame_data is sampled only on the capture edge; changes at other times are ignored.
- rst asserted mid-frame: the stream is abandoned immediately and all state returns to reset values. No partial frame is resumed after release.

Decomposition:
- Shared package fft_pkg holds:
  - SAMPLE_W=32 and COMP_W=16
  - the complex sample typedef {re, im}
  - bitrev function (index, width)
  - the LEN default, shared with the fft and its bench
- One natural sub-module: fft_frame_slot. It is one LEN*32 storage register with a full/draining flag and indexed read mux, instantiated twice.
- Top level holds the pointers, counter, scaling and handshake.

Test Plan:
- Single frame, natural order. Sample j = {re=j+1, im=-(j+1)}, out_ready=1. Required: out_valid 1 cycle after capture; 8 consecutive samples 0x0001FFFF, 0x0002FFFE, … 0x0008FFF8; out_last only on index 7.
- BITREV=1, same frame. Required: out_index sequence 0,4,2,6,1,5,3,7 with matching data; out_last on the 8th transfer (index 7).
- Backpressure. out_ready toggles 1,0,0,1 repeating. Required: data/index stable through each stall; exactly 8 transfers; no duplicate or skipped index.
- Ping-pong and overflow, out_ready=0. Pulse frame_valid 3 times (frames A, B, C). Required: A and B captured, frame_ready=0 after B; C dropped with one overflow pulse. Then with out_ready=1: 16 samples with no bubble between A and B, all of A before B.
- SHIFT=2. Sample re=0x8000, im=0x0007. Required: out_data = 0xE0000001.
- Reset mid-stream. Assert rst after 3 transfers of a frame. Required: out_valid=0 and frame_ready=1 immediately (asynchronous); after release the next captured frame starts at index 0.
